// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data-port memory requests onto one physical memory port.
// Data requests win over fetch; each access ends with a one-cycle resp pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                inst_read,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_resp,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_mbe,
  output logic                data_resp,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_mbe,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    INST,
    DREAD,
    DWRITE,
    IRESP,
    DRESP
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      inst_resp    <= 1'b0;
      data_resp    <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_mbe     <= '0;
    end else begin
      inst_resp <= 1'b0;
      data_resp <= 1'b0;
      case (state)
        // A write also wins when data_read is (illegally) high alongside it.
        IDLE: begin
          if (data_write) begin
            state        <= DWRITE;
            pmem_write   <= 1'b1;
            pmem_address <= data_addr;
            pmem_wdata   <= data_wdata;
            pmem_mbe     <= data_mbe;
          end else if (data_read) begin
            state        <= DREAD;
            pmem_read    <= 1'b1;
            pmem_address <= data_addr;
          end else if (inst_read) begin
            state        <= INST;
            pmem_read    <= 1'b1;
            pmem_address <= inst_addr;
          end
        end
        INST: begin
          if (pmem_resp) begin
            state      <= IRESP;
            pmem_read  <= 1'b0;
            inst_rdata <= pmem_rdata;
            inst_resp  <= 1'b1;
          end
        end
        DREAD: begin
          if (pmem_resp) begin
            state      <= DRESP;
            pmem_read  <= 1'b0;
            data_rdata <= pmem_rdata;
            data_resp  <= 1'b1;
          end
        end
        DWRITE: begin
          if (pmem_resp) begin
            state      <= DRESP;
            pmem_write <= 1'b0;
            data_resp  <= 1'b1;
          end
        end
        // Requests are not re-granted during the resp cycle; IDLE samples them afresh.
        IRESP, DRESP: state <= IDLE;
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both the pipeline and the memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mbe;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_mbe;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_resp    (inst_resp),
    .inst_rdata   (inst_rdata),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_mbe     (data_mbe),
    .data_resp    (data_resp),
    .data_rdata   (data_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_mbe     (pmem_mbe),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pr"}, 32'(pmem_read), 32'd0);
    check({tag, "_pw"}, 32'(pmem_write), 32'd0);
    check({tag, "_ir"}, 32'(inst_resp), 32'd0);
    check({tag, "_dr"}, 32'(data_resp), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    inst_read = 1'b0; inst_addr = '0;
    data_read = 1'b0; data_write = 1'b0; data_addr = '0;
    data_wdata = '0; data_mbe = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset values and idle
    check("rst_addr", pmem_address, 32'h0);
    check("rst_wdata", pmem_wdata, 32'h0);
    check("rst_mbe", 32'(pmem_mbe), 32'h0);
    check("rst_irdata", inst_rdata, 32'h0);
    check("rst_drdata", data_rdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("idle");
    end

    // Single fetch, memory responds at T+3
    inst_read = 1'b1; inst_addr = 32'h60;
    check("f_T_pr", 32'(pmem_read), 32'd0);
    tick();
    check("f_T1_pr", 32'(pmem_read), 32'd1);
    check("f_T1_addr", pmem_address, 32'h60);
    check("f_T1_pw", 32'(pmem_write), 32'd0);
    tick();
    check("f_T2_pr", 32'(pmem_read), 32'd1);
    check("f_T2_ir", 32'(inst_resp), 32'd0);
    tick();
    check("f_T3_pr", 32'(pmem_read), 32'd1);
    pmem_resp = 1'b1; pmem_rdata = 32'h00A00093;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("f_T4_ir", 32'(inst_resp), 32'd1);
    check("f_T4_rdata", inst_rdata, 32'h00A00093);
    check("f_T4_pr", 32'(pmem_read), 32'd0);
    check("f_T4_dr", 32'(data_resp), 32'd0);
    inst_read = 1'b0;
    tick();
    check_quiet("f_T5");
    check("f_T5_hold", inst_rdata, 32'h00A00093);

    // Store, memory responds two cycles after the strobe
    data_write = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEADBEEF; data_mbe = 4'b0011;
    tick();
    check("w_T1_pw", 32'(pmem_write), 32'd1);
    check("w_T1_pr", 32'(pmem_read), 32'd0);
    check("w_T1_addr", pmem_address, 32'h100);
    check("w_T1_wdata", pmem_wdata, 32'hDEADBEEF);
    check("w_T1_mbe", 32'(pmem_mbe), 32'h3);
    data_wdata = 32'h12345678; data_mbe = 4'b1100; data_addr = 32'h444;
    tick();
    check("w_T2_pw", 32'(pmem_write), 32'd1);
    check("w_T2_wdata", pmem_wdata, 32'hDEADBEEF);
    check("w_T2_mbe", 32'(pmem_mbe), 32'h3);
    check("w_T2_addr", pmem_address, 32'h100);
    tick();
    check("w_T3_pw", 32'(pmem_write), 32'd1);
    check("w_T3_dr", 32'(data_resp), 32'd0);
    pmem_resp = 1'b1; pmem_rdata = 32'hCAFEF00D;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("w_T4_dr", 32'(data_resp), 32'd1);
    check("w_T4_pw", 32'(pmem_write), 32'd0);
    check("w_T4_rdata", data_rdata, 32'h0);
    data_write = 1'b0;
    tick();
    check_quiet("w_T5");

    // Fetch and load together: load first
    inst_read = 1'b1; inst_addr = 32'h64;
    data_read = 1'b1; data_addr = 32'h200;
    tick();
    check("a_T1_pr", 32'(pmem_read), 32'd1);
    check("a_T1_addr", pmem_address, 32'h200);
    pmem_resp = 1'b1; pmem_rdata = 32'h11112222;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("a_T2_dr", 32'(data_resp), 32'd1);
    check("a_T2_ir", 32'(inst_resp), 32'd0);
    check("a_T2_rdata", data_rdata, 32'h11112222);
    data_read = 1'b0;
    tick();
    check_quiet("a_T3");
    tick();
    check("a_T4_pr", 32'(pmem_read), 32'd1);
    check("a_T4_addr", pmem_address, 32'h64);
    pmem_resp = 1'b1; pmem_rdata = 32'h33334444;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("a_T5_ir", 32'(inst_resp), 32'd1);
    check("a_T5_dr", 32'(data_resp), 32'd0);
    check("a_T5_rdata", inst_rdata, 32'h33334444);
    check("a_T5_dhold", data_rdata, 32'h11112222);
    inst_read = 1'b0;
    tick();
    check_quiet("a_T6");

    // Stray pmem_resp while idle is ignored
    pmem_resp = 1'b1; pmem_rdata = 32'h5A5A5A5A;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check_quiet("stray1");
    tick();
    check_quiet("stray2");
    check("stray_ird", inst_rdata, 32'h33334444);

    // Read and write both high: treated as a write
    data_read = 1'b1; data_write = 1'b1; data_addr = 32'h180;
    data_wdata = 32'hA5A5A5A5; data_mbe = 4'b1111;
    tick();
    check("rw_pw", 32'(pmem_write), 32'd1);
    check("rw_pr", 32'(pmem_read), 32'd0);
    check("rw_wdata", pmem_wdata, 32'hA5A5A5A5);
    pmem_resp = 1'b1; pmem_rdata = 32'h77777777;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("rw_dr", 32'(data_resp), 32'd1);
    check("rw_rdata", data_rdata, 32'h11112222);
    data_read = 1'b0; data_write = 1'b0;
    tick();
    check_quiet("rw_end");

    // Reset in the middle of a load; late pmem_resp after reset
    data_read = 1'b1; data_addr = 32'h300;
    tick();
    check("r_T1_pr", 32'(pmem_read), 32'd1);
    check("r_T1_addr", pmem_address, 32'h300);
    tick();
    rst = 1'b1; data_read = 1'b0;
    tick();
    rst = 1'b0;
    check("r_T3_pr", 32'(pmem_read), 32'd0);
    check("r_T3_addr", pmem_address, 32'h0);
    pmem_resp = 1'b1; pmem_rdata = 32'h99999999;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check_quiet("r_T4");
    check("r_T4_rdata", data_rdata, 32'h0);
    tick();
    check_quiet("r_T5");

    // Fetch held high across its resp starts a second fetch
    inst_read = 1'b1; inst_addr = 32'h68;
    tick();
    check("b_T1_pr", 32'(pmem_read), 32'd1);
    check("b_T1_addr", pmem_address, 32'h68);
    pmem_resp = 1'b1; pmem_rdata = 32'hAAAA0001;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("b_T2_ir", 32'(inst_resp), 32'd1);
    check("b_T2_rdata", inst_rdata, 32'hAAAA0001);
    tick();
    check_quiet("b_T3");
    tick();
    check("b_T4_pr", 32'(pmem_read), 32'd1);
    check("b_T4_ir", 32'(inst_resp), 32'd0);
    pmem_resp = 1'b1; pmem_rdata = 32'hAAAA0002;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("b_T5_ir", 32'(inst_resp), 32'd1);
    check("b_T5_rdata", inst_rdata, 32'hAAAA0002);
    inst_read = 1'b0;
    tick();
    check_quiet("b_T6");
    tick();
    check_quiet("b_T7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
